// File: rtl/icache_refill_pkg.sv
// Shared types, geometry constants and helpers for the direct-mapped instruction cache.
package icache_refill_pkg;

    localparam int unsigned INDEX_W_DEF = 6;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned LINE_W      = 128;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned OFFSET_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Extract 32-bit word w from a line; byte k of the line sits at [8k+7:8k].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        w);
        return line[{w, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port,
// valid bits cleared asynchronously on reset.
module icache_line_array
    import icache_refill_pkg::*;
#(
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned TAG_W   = ADDR_W_DEF - OFFSET_W - INDEX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_c_o,
    output logic [TAG_W-1:0]   rd_tag_c_o,
    output logic [LINE_W-1:0]  rd_data_c_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [LINE_W-1:0]  wr_data_i
);

    localparam int unsigned NLINES = 1 << INDEX_W;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (en_i && we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data are plain storage; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_c_o = valid_q[rd_index_i];
    assign rd_tag_c_o   = tag_q[rd_index_i];
    assign rd_data_c_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache: serves fetches from 16-byte lines, refills misses
// from mem_ctrler over a valid/ready line protocol, and honours ROB flushes.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] addr_from_fetcher,
    input  logic              valid_from_fetcher,
    input  logic              flush_from_rob,
    output logic              ready_to_fetcher,
    output logic [WORD_W-1:0] inst_to_fetcher,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic              valid_to_mem,
    input  logic              ready_from_mem,
    input  logic [LINE_W-1:0] data_from_mem
);

    localparam int unsigned TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned TAG_LO = OFFSET_W + INDEX_W;

    state_e            state_q, state_d;
    logic              discard_q, discard_d;
    logic              ready_q, ready_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic              vmem_q, vmem_d;
    logic [ADDR_W-1:0] amem_q, amem_d;
    logic [1:0]        word_q, word_d;

    logic              rd_valid_c;
    logic [TAG_W-1:0]  rd_tag_c;
    logic [LINE_W-1:0] rd_data_c;
    logic              we_c;
    logic              hit_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr_from_fetcher[1:0];

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk          (clk),
        .rst_ni       (rst),
        .en_i         (rdy),
        .rd_index_i   (addr_from_fetcher[TAG_LO-1:OFFSET_W]),
        .rd_valid_c_o (rd_valid_c),
        .rd_tag_c_o   (rd_tag_c),
        .rd_data_c_o  (rd_data_c),
        .we_i         (we_c),
        .wr_index_i   (amem_q[TAG_LO-1:OFFSET_W]),
        .wr_tag_i     (amem_q[ADDR_W-1:TAG_LO]),
        .wr_data_i    (data_from_mem)
    );

    assign hit_c = rd_valid_c && (rd_tag_c == addr_from_fetcher[ADDR_W-1:TAG_LO]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            ready_q   <= 1'b0;
            inst_q    <= '0;
            vmem_q    <= 1'b0;
            amem_q    <= '0;
            word_q    <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            discard_q <= discard_d;
            ready_q   <= ready_d;
            inst_q    <= inst_d;
            vmem_q    <= vmem_d;
            amem_q    <= amem_d;
            word_q    <= word_d;
        end
    end

    // Next-state and output decode; ready is a pulse so it defaults low every cycle.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        ready_d   = 1'b0;
        inst_d    = inst_q;
        vmem_d    = vmem_q;
        amem_d    = amem_q;
        word_d    = word_q;
        we_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A pending pulse blocks acceptance so a held request is served once.
                if (valid_from_fetcher && !ready_q && !flush_from_rob) begin
                    word_d = addr_from_fetcher[3:2];
                    if (hit_c) begin
                        ready_d = 1'b1;
                        inst_d  = line_word(rd_data_c, addr_from_fetcher[3:2]);
                    end else begin
                        vmem_d  = 1'b1;
                        amem_d  = {addr_from_fetcher[ADDR_W-1:OFFSET_W], 4'b0};
                        state_d = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (flush_from_rob) begin
                    discard_d = 1'b1;
                end
                // The refill cannot be aborted, so the line is always installed.
                if (ready_from_mem) begin
                    we_c   = 1'b1;
                    vmem_d = 1'b0;
                    if (discard_q || flush_from_rob) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        ready_d = 1'b1;
                        inst_d  = line_word(data_from_mem, word_q);
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready_to_fetcher = ready_q;
    assign inst_to_fetcher  = inst_q;
    assign valid_to_mem     = vmem_q;
    assign addr_to_mem      = amem_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill with a hand-driven mem_ctrler model.
module tb_icache_refill;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic [31:0]  addr_from_fetcher;
    logic         valid_from_fetcher;
    logic         flush_from_rob;
    logic         ready_to_fetcher;
    logic [31:0]  inst_to_fetcher;
    logic [31:0]  addr_to_mem;
    logic         valid_to_mem;
    logic         ready_from_mem;
    logic [127:0] data_from_mem;

    int checks;
    int failures;

    icache_refill dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .addr_from_fetcher  (addr_from_fetcher),
        .valid_from_fetcher (valid_from_fetcher),
        .flush_from_rob     (flush_from_rob),
        .ready_to_fetcher   (ready_to_fetcher),
        .inst_to_fetcher    (inst_to_fetcher),
        .addr_to_mem        (addr_to_mem),
        .valid_to_mem       (valid_to_mem),
        .ready_from_mem     (ready_from_mem),
        .data_from_mem      (data_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
        return l;
    endfunction

    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_inst);
        addr_from_fetcher  = addr;
        valid_from_fetcher = 1'b1;
        tick();
        check({tag, "_rdy"}, 32'(ready_to_fetcher), 32'd1);
        check({tag, "_inst"}, inst_to_fetcher, exp_inst);
        check({tag, "_vmem"}, 32'(valid_to_mem), 32'd0);
        valid_from_fetcher = 1'b0;
        tick();
        check({tag, "_rdy_off"}, 32'(ready_to_fetcher), 32'd0);
    endtask

    task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [31:0] exp_laddr,
                              input logic [127:0] line, input int waits, input logic [31:0] exp_inst);
        addr_from_fetcher  = addr;
        valid_from_fetcher = 1'b1;
        tick();
        check({tag, "_vmem"}, 32'(valid_to_mem), 32'd1);
        check({tag, "_amem"}, addr_to_mem, exp_laddr);
        check({tag, "_rdy_early"}, 32'(ready_to_fetcher), 32'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, "_vmem_hold"}, 32'(valid_to_mem), 32'd1);
        end
        ready_from_mem = 1'b1;
        data_from_mem  = line;
        tick();
        ready_from_mem = 1'b0;
        data_from_mem  = '0;
        check({tag, "_rdy"}, 32'(ready_to_fetcher), 32'd1);
        check({tag, "_inst"}, inst_to_fetcher, exp_inst);
        check({tag, "_vmem_drop"}, 32'(valid_to_mem), 32'd0);
        valid_from_fetcher = 1'b0;
        tick();
        check({tag, "_rdy_off"}, 32'(ready_to_fetcher), 32'd0);
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b0;
        rdy                = 1'b1;
        addr_from_fetcher  = '0;
        valid_from_fetcher = 1'b0;
        flush_from_rob     = 1'b0;
        ready_from_mem     = 1'b0;
        data_from_mem      = '0;

        tick();
        tick();
        check("rst_rdy", 32'(ready_to_fetcher), 32'd0);
        check("rst_inst", inst_to_fetcher, 32'd0);
        check("rst_vmem", 32'(valid_to_mem), 32'd0);
        check("rst_amem", addr_to_mem, 32'd0);
        rst = 1'b1;
        tick();

        // Cold miss then hits in the same line.
        fetch_miss("cold", 32'h0000_1008, 32'h0000_1000, mk_line(8'h00), 2, 32'h0B0A_0908);
        fetch_hit("hit_c", 32'h0000_100C, 32'h0F0E_0D0C);
        fetch_hit("hit_0", 32'h0000_1003, 32'h0302_0100);

        // Flush while the refill is outstanding: line installed, no pulse.
        addr_from_fetcher  = 32'h0000_2014;
        valid_from_fetcher = 1'b1;
        tick();
        check("fl_vmem", 32'(valid_to_mem), 32'd1);
        check("fl_amem", addr_to_mem, 32'h0000_2010);
        valid_from_fetcher = 1'b0;
        flush_from_rob     = 1'b1;
        tick();
        flush_from_rob = 1'b0;
        check("fl_vmem_hold", 32'(valid_to_mem), 32'd1);
        ready_from_mem = 1'b1;
        data_from_mem  = mk_line(8'h20);
        tick();
        ready_from_mem = 1'b0;
        check("fl_no_pulse", 32'(ready_to_fetcher), 32'd0);
        check("fl_vmem_drop", 32'(valid_to_mem), 32'd0);
        tick();
        check("fl_no_pulse2", 32'(ready_to_fetcher), 32'd0);
        fetch_hit("fl_refetch", 32'h0000_2018, 32'h2B2A_2928);
        fetch_hit("fl_refetch0", 32'h0000_1000, 32'h0302_0100);

        // Flush coinciding with the refill delivery.
        addr_from_fetcher  = 32'h0000_3020;
        valid_from_fetcher = 1'b1;
        tick();
        check("flr_vmem", 32'(valid_to_mem), 32'd1);
        valid_from_fetcher = 1'b0;
        ready_from_mem     = 1'b1;
        flush_from_rob     = 1'b1;
        data_from_mem      = mk_line(8'h60);
        tick();
        ready_from_mem = 1'b0;
        flush_from_rob = 1'b0;
        check("flr_no_pulse", 32'(ready_to_fetcher), 32'd0);
        tick();
        check("flr_no_pulse2", 32'(ready_to_fetcher), 32'd0);
        fetch_hit("flr_hit", 32'h0000_3024, 32'h6766_6564);

        // Flush in IDLE beats a simultaneous hit accept.
        addr_from_fetcher  = 32'h0000_1004;
        valid_from_fetcher = 1'b1;
        flush_from_rob     = 1'b1;
        tick();
        valid_from_fetcher = 1'b0;
        flush_from_rob     = 1'b0;
        check("fli_no_pulse", 32'(ready_to_fetcher), 32'd0);
        check("fli_vmem", 32'(valid_to_mem), 32'd0);
        tick();

        // Conflict on index 0 evicts the earlier line.
        fetch_miss("conf", 32'h0000_1400, 32'h0000_1400, mk_line(8'h40), 0, 32'h4342_4140);
        fetch_miss("conf_back", 32'h0000_1004, 32'h0000_1000, mk_line(8'h00), 1, 32'h0706_0504);

        // Held valid across the pulse yields a single pulse.
        addr_from_fetcher  = 32'h0000_1008;
        valid_from_fetcher = 1'b1;
        tick();
        check("b2b_rdy", 32'(ready_to_fetcher), 32'd1);
        check("b2b_inst", inst_to_fetcher, 32'h0B0A_0908);
        tick();
        check("b2b_no_second", 32'(ready_to_fetcher), 32'd0);
        valid_from_fetcher = 1'b0;
        tick();
        check("b2b_idle", 32'(ready_to_fetcher), 32'd0);

        // rdy low for three cycles mid-miss holds everything.
        addr_from_fetcher  = 32'h0000_4034;
        valid_from_fetcher = 1'b1;
        tick();
        check("frz_vmem", 32'(valid_to_mem), 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_vmem_hold", 32'(valid_to_mem), 32'd1);
            check("frz_amem_hold", addr_to_mem, 32'h0000_4030);
            check("frz_rdy", 32'(ready_to_fetcher), 32'd0);
        end
        rdy = 1'b1;
        ready_from_mem = 1'b1;
        data_from_mem  = mk_line(8'h80);
        tick();
        ready_from_mem = 1'b0;
        check("frz_rdy_pulse", 32'(ready_to_fetcher), 32'd1);
        check("frz_inst", inst_to_fetcher, 32'h8786_8584);
        valid_from_fetcher = 1'b0;
        tick();

        // Reset asserted mid-miss clears outputs and the valid bits.
        addr_from_fetcher  = 32'h0000_5040;
        valid_from_fetcher = 1'b1;
        tick();
        check("rm_vmem", 32'(valid_to_mem), 32'd1);
        valid_from_fetcher = 1'b0;
        rst = 1'b0;
        tick();
        check("rm_vmem_clr", 32'(valid_to_mem), 32'd0);
        check("rm_rdy_clr", 32'(ready_to_fetcher), 32'd0);
        rst = 1'b1;
        tick();
        fetch_miss("rm_refetch0", 32'h0000_0000, 32'h0000_0000, mk_line(8'hA0), 0, 32'hA3A2_A1A0);
        fetch_miss("rm_1000_gone", 32'h0000_1000, 32'h0000_1000, mk_line(8'h00), 0, 32'h0302_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
